// File: rtl/video_capture_fb.sv
// Capture path: 640x480 DE/vsync pixel stream downscaled 8x8 into a
// double-buffered 80x60 RGB framebuffer write port.
module video_capture_fb #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int XRES    = 80,
  parameter int YRES    = 60,
  parameter int VPOL    = 1
) (
  input  logic        clk_pclk,
  input  logic        resetn,
  input  logic        vid_de,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  input  logic [23:0] vid_rgb,
  input  logic        arm,
  input  logic        continuous,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_seg,
  output logic        active_seg,
  output logic        busy,
  output logic        frame_done,
  output logic        err_geom
);

  localparam logic [9:0]  HACT   = 10'(HACTIVE);
  localparam logic [8:0]  VACT   = 9'(VACTIVE);
  localparam logic [12:0] XRES_W = 13'(XRES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        de_q, vs_q;
  logic [9:0]  pix_q, pix_d;
  logic [8:0]  line_q, line_d;
  logic [10:0] acc_r_q, acc_g_q, acc_b_q;
  logic [10:0] acc_r_d, acc_g_d, acc_b_d;
  logic        wr_en_q, wr_en_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [23:0] wr_data_q, wr_data_d;
  logic        wr_seg_q, wr_seg_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        vs_act, vs_start, de_rise, de_fall;
  logic [9:0]  pix_cur;
  logic [10:0] sum_r, sum_g, sum_b;
  logic        use_px, geom_bad;

  // hsync carries no information needed for counting
  logic unused_ok;
  assign unused_ok = &{1'b0, vid_hsync, YRES[0]};

  assign vs_act   = (VPOL != 0) ? vid_vsync : ~vid_vsync;
  assign vs_start = vs_act & ~vs_q;
  assign de_rise  = vid_de & ~de_q;
  assign de_fall  = ~vid_de & de_q;

  // The first pixel of a line must already see pix==0, so the clear on
  // de_rise is applied combinationally to the value used this cycle.
  assign pix_cur = de_rise ? '0 : pix_q;

  assign sum_r = acc_r_q + {3'b000, vid_rgb[23:16]};
  assign sum_g = acc_g_q + {3'b000, vid_rgb[15:8]};
  assign sum_b = acc_b_q + {3'b000, vid_rgb[7:0]};

  assign use_px = vid_de && (line_q[2:0] == 3'd0) && (pix_cur < HACT) && (line_q < VACT);
  assign geom_bad = (de_fall && (pix_q != HACT)) || (de_rise && (line_q >= VACT));

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    acc_r_d   = acc_r_q;
    acc_g_d   = acc_g_q;
    acc_b_d   = acc_b_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_seg_d  = wr_seg_q;
    active_d  = active_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_WAIT_VSYNC;
          err_d   = 1'b0;
        end
      end

      S_WAIT_VSYNC: begin
        if (vs_start) begin
          state_d  = S_CAPTURE;
          pix_d    = '0;
          line_d   = '0;
          acc_r_d  = '0;
          acc_g_d  = '0;
          acc_b_d  = '0;
          wr_seg_d = ~active_q;
        end
      end

      S_CAPTURE: begin
        if (vid_de)
          pix_d = (pix_cur == '1) ? pix_cur : pix_cur + 10'd1;
        if (de_fall)
          line_d = (line_q == '1) ? line_q : line_q + 9'd1;

        if (use_px) begin
          if (pix_cur[2:0] == 3'd7) begin
            wr_en_d   = 1'b1;
            wr_data_d = {sum_r[10:3], sum_g[10:3], sum_b[10:3]};
            wr_addr_d = {7'b0, line_q[8:3]} * XRES_W + {6'b0, pix_cur[9:3]};
            acc_r_d   = '0;
            acc_g_d   = '0;
            acc_b_d   = '0;
          end else begin
            acc_r_d = sum_r;
            acc_g_d = sum_g;
            acc_b_d = sum_b;
          end
        end

        if (geom_bad)
          err_d = 1'b1;

        // vsync abort wins over a coincident end-of-frame de_fall
        if (vs_start) begin
          err_d   = 1'b1;
          wr_en_d = 1'b0;
          state_d = S_DONE;
        end else if (de_fall && (line_q == VACT - 9'd1)) begin
          state_d = S_DONE;
          if (!(err_q || geom_bad)) begin
            active_d = ~active_q;
            done_d   = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = continuous ? S_WAIT_VSYNC : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pclk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      de_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      acc_r_q   <= '0;
      acc_g_q   <= '0;
      acc_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_seg_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      de_q      <= vid_de;
      vs_q      <= vs_act;
      pix_q     <= pix_d;
      line_q    <= line_d;
      acc_r_q   <= acc_r_d;
      acc_g_q   <= acc_g_d;
      acc_b_q   <= acc_b_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_seg_q  <= wr_seg_d;
      active_q  <= active_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_seg     = wr_seg_q;
  assign active_seg = active_q;
  assign busy       = (state_q == S_WAIT_VSYNC) || (state_q == S_CAPTURE);
  assign frame_done = done_q;
  assign err_geom   = err_q;

endmodule

// File: tb/tb_video_capture_fb.sv
// Scoreboard bench for video_capture_fb on a reduced 64x48 -> 8x6 geometry.
module tb_video_capture_fb;

  localparam int HACT      = 64;
  localparam int VACT      = 48;
  localparam int XR        = 8;
  localparam int YR        = 6;
  localparam int HBLANK    = 6;
  localparam int ABORT_PIX = 20;

  logic        clk_pclk = 1'b0;
  logic        resetn = 1'b0;
  logic        vid_de = 1'b0, vid_hsync = 1'b0, vid_vsync = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic        arm = 1'b0, continuous = 1'b0;
  logic        wr_en, wr_seg, active_seg, busy, frame_done, err_geom;
  logic [12:0] wr_addr;
  logic [23:0] wr_data;

  video_capture_fb #(.HACTIVE(HACT), .VACTIVE(VACT), .XRES(XR), .YRES(YR), .VPOL(1)) dut (
    .clk_pclk(clk_pclk), .resetn(resetn), .vid_de(vid_de), .vid_hsync(vid_hsync),
    .vid_vsync(vid_vsync), .vid_rgb(vid_rgb), .arm(arm), .continuous(continuous),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_seg(wr_seg),
    .active_seg(active_seg), .busy(busy), .frame_done(frame_done), .err_geom(err_geom)
  );

  always #5 clk_pclk = ~clk_pclk;

  typedef struct packed {
    logic [12:0] a;
    logic [23:0] d;
    logic        s;
  } wr_t;

  wr_t  exp_q[$];
  logic fd_q[$];
  int   total = 0;
  int   bad = 0;
  logic exp_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pclk);
    #1;
  endtask

  function automatic logic [23:0] pixel(input int mode, input int l, input int p);
    case (mode)
      0: return 24'h102030;
      1: return (l == 0) ? {p[7:0], 16'h0000} : 24'h102030;
      2: return (l % 8 == 0) ? 24'h000000 : 24'hFFFFFF;
      default: return {l[7:0], p[7:0], 8'h5A};
    endcase
  endfunction

  function automatic logic [23:0] box_avg(input int mode, input int l, input int c);
    int sr = 0, sg = 0, sb = 0;
    logic [23:0] px;
    for (int k = 0; k < 8; k++) begin
      px = pixel(mode, l, 8 * c + k);
      sr += px[23:16];
      sg += px[15:8];
      sb += px[7:0];
    end
    return {8'(sr / 8), 8'(sg / 8), 8'(sb / 8)};
  endfunction

  task automatic push_line(input int mode, input int l, input int ncols, input logic seg);
    wr_t e;
    for (int c = 0; c < ncols; c++) begin
      e.a = 13'((l / 8) * XR + c);
      e.d = box_avg(mode, l, c);
      e.s = seg;
      exp_q.push_back(e);
    end
  endtask

  // One frame; bad_line gets one pixel short, abort_line pulses resetn mid-line.
  task automatic drive_frame(input int mode, input int bad_line, input int abort_line,
                             input bit expect_wr);
    logic seg;
    seg = ~exp_active;
    if (expect_wr && bad_line < 0 && abort_line < 0) begin
      exp_active = ~exp_active;
      fd_q.push_back(exp_active);
    end
    vid_vsync = 1'b1;
    repeat (2) tick();
    vid_vsync = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < VACT; l++) begin
      int n;
      n = (l == bad_line) ? HACT - 1 : HACT;
      if (expect_wr && (l % 8 == 0)) begin
        if (l == abort_line) push_line(mode, l, ABORT_PIX / 8, seg);
        else push_line(mode, l, XR, seg);
      end
      for (int p = 0; p < n; p++) begin
        if (l == abort_line && p == ABORT_PIX) begin
          resetn = 1'b0;
          vid_de = 1'b0;
          vid_rgb = '0;
          tick();
          resetn = 1'b1;
          exp_active = 1'b0;
          chk("rst_wr_en", {31'b0, wr_en}, 0);
          chk("rst_busy", {31'b0, busy}, 0);
          chk("rst_active_seg", {31'b0, active_seg}, 0);
          chk("rst_wr_seg", {31'b0, wr_seg}, 1);
          return;
        end
        vid_de = 1'b1;
        vid_rgb = pixel(mode, l, p);
        tick();
      end
      vid_de = 1'b0;
      vid_rgb = '0;
      vid_hsync = 1'b1;
      repeat (2) tick();
      vid_hsync = 1'b0;
      repeat (HBLANK - 2) tick();
    end
    repeat (8) tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_wr_left"}, exp_q.size(), 0);
    chk({name, "_fd_left"}, fd_q.size(), 0);
  endtask

  always @(negedge clk_pclk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {19'b0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {19'b0, wr_addr}, {19'b0, e.a});
        chk("wr_data", {8'b0, wr_data}, {8'b0, e.d});
        chk("wr_seg", {31'b0, wr_seg}, {31'b0, e.s});
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        chk("unexpected_frame_done", {31'b0, active_seg}, 32'hFFFF_FFFF);
      end else begin
        logic ea;
        ea = fd_q.pop_front();
        chk("fd_active_seg", {31'b0, active_seg}, {31'b0, ea});
        chk("fd_pending_writes", exp_q.size(), 0);
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("reset_wr_en", {31'b0, wr_en}, 0);
    chk("reset_wr_addr", {19'b0, wr_addr}, 0);
    chk("reset_wr_data", {8'b0, wr_data}, 0);
    chk("reset_active_seg", {31'b0, active_seg}, 0);
    chk("reset_wr_seg", {31'b0, wr_seg}, 1);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_frame_done", {31'b0, frame_done}, 0);
    chk("reset_err_geom", {31'b0, err_geom}, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // constant frame
    pulse_arm();
    chk("armed_busy", {31'b0, busy}, 1);
    drive_frame(0, -1, -1, 1'b1);
    chk_drained("const");
    chk("const_active", {31'b0, active_seg}, 1);
    chk("const_idle", {31'b0, busy}, 0);

    // gradient on line 0 (col0 avg 3, col1 avg 11)
    pulse_arm();
    drive_frame(1, -1, -1, 1'b1);
    chk_drained("grad");
    chk("grad_active", {31'b0, active_seg}, 0);

    // decimated lines carry white, sampled lines black
    pulse_arm();
    drive_frame(2, -1, -1, 1'b1);
    chk_drained("decim");

    // continuous: three frames with auto re-arm
    continuous = 1'b1;
    pulse_arm();
    drive_frame(3, -1, -1, 1'b1);
    chk("cont1_busy", {31'b0, busy}, 1);
    drive_frame(0, -1, -1, 1'b1);
    chk("cont2_busy", {31'b0, busy}, 1);
    continuous = 1'b0;
    drive_frame(1, -1, -1, 1'b1);
    chk_drained("cont");
    chk("cont3_busy", {31'b0, busy}, 0);
    chk("cont_active", {31'b0, active_seg}, {31'b0, exp_active});

    // short line -> geometry error, no swap
    pulse_arm();
    drive_frame(3, 13, -1, 1'b1);
    chk_drained("geom");
    chk("geom_err", {31'b0, err_geom}, 1);
    chk("geom_active", {31'b0, active_seg}, {31'b0, exp_active});
    pulse_arm();
    chk("arm_clears_err", {31'b0, err_geom}, 0);
    drive_frame(0, -1, -1, 1'b1);
    chk_drained("recover");

    // reset mid-frame, then an unarmed frame must produce nothing
    pulse_arm();
    drive_frame(0, -1, 24, 1'b1);
    drive_frame(0, -1, -1, 1'b0);
    chk_drained("abort");
    chk("abort_err", {31'b0, err_geom}, 0);
    pulse_arm();
    drive_frame(3, -1, -1, 1'b1);
    chk_drained("post_reset");
    chk("post_reset_active", {31'b0, active_seg}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
